// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: state encoding and shared constants for the DDR round-robin arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  localparam logic [7:0] BURST_MIN = 8'd1;

  // A requested burst of zero is served as a single beat.
  function automatic logic [7:0] eff_burst(input logic [7:0] b);
    return (b == 8'd0) ? BURST_MIN : b;
  endfunction

endpackage

// File: rtl/ddr_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first pending channel at or after rr with wrap.
module rr_pick
  import ddr_arb_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int RR_W = 3
) (
  input  logic [NCH-1:0]  pending,
  input  logic [RR_W-1:0] rr,
  output logic [RR_W-1:0] grant,
  output logic            valid
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [IDX_W-1:0] idx;

  // Scan downward in distance from rr so the closest pending channel wins last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr) + k) % NCH);
      if (pending[idx]) begin
        grant = RR_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_arb.sv
// ddr_arb: round-robin scheduler sharing one 64-bit Avalon-MM DDR port among NCH
// toggle-handshake requesters, one read or write burst in flight at a time.
module ddr_arb
  import ddr_arb_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int RR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_waitrequest,
  output logic [7:0]            ram_burstcnt,
  output logic [28:0]           ram_addr,
  input  logic [63:0]           ram_readdata,
  input  logic                  ram_read_ready,
  output logic                  ram_read,
  output logic [63:0]           ram_writedata,
  output logic [7:0]            ram_byteenable,
  output logic                  ram_write,
  input  logic [NCH-1:0][31:3]  ch_addr,
  input  logic [NCH-1:0][7:0]   ch_burst,
  input  logic [NCH-1:0]        ch_we,
  input  logic [NCH-1:0]        ch_req,
  output logic [NCH-1:0]        ch_ack,
  input  logic [NCH-1:0][63:0]  ch_wdata,
  input  logic [NCH-1:0][7:0]   ch_be,
  output logic [NCH-1:0]        ch_wr_next,
  output logic [63:0]           ch_rdata,
  output logic [NCH-1:0]        ch_ready,
  output logic                  busy
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state;
  logic [RR_W-1:0]   rr;
  logic [IDX_W-1:0]  gidx;
  logic [7:0]        count;
  logic [NCH-1:0]    pending;
  logic [RR_W-1:0]   pick;
  logic              pick_valid;
  logic [IDX_W-1:0]  pidx;

  assign pending = ch_req ^ ch_ack;
  assign pidx    = pick[IDX_W-1:0];
  assign busy    = (state != IDLE);

  rr_pick #(
    .NCH  (NCH),
    .RR_W (RR_W)
  ) u_pick (
    .pending (pending),
    .rr      (rr),
    .grant   (pick),
    .valid   (pick_valid)
  );

  // Write beats flow straight from the granted requester; reads drive all enables.
  assign ram_writedata = ch_wdata[gidx];

  // Byte enables and the per-channel next-beat strobe follow the live stall signal.
  always_comb begin
    ram_byteenable = 8'hFF;
    ch_wr_next     = '0;
    if (state == WR) begin
      ram_byteenable   = ch_be[gidx];
      ch_wr_next[gidx] = ram_write & ~ram_waitrequest;
    end
  end

  // Arbitration and transaction FSM with registered command and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr           <= '0;
      gidx         <= '0;
      count        <= '0;
      ram_read     <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_burstcnt <= '0;
      ch_ack       <= '0;
      ch_ready     <= '0;
      ch_rdata     <= '0;
    end else begin
      ch_ready <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gidx         <= pidx;
            ram_addr     <= ch_addr[pidx];
            ram_burstcnt <= eff_burst(ch_burst[pidx]);
            count        <= '0;
            rr           <= (pick == RR_W'(NCH - 1)) ? '0 : pick + 1'b1;
            if (ch_we[pidx]) begin
              ram_write <= 1'b1;
              state     <= WR;
            end else begin
              ram_read <= 1'b1;
              state    <= RD_CMD;
            end
          end
        end
        RD_CMD: begin
          if (!ram_waitrequest) begin
            ram_read <= 1'b0;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (ram_read_ready) begin
            ch_rdata       <= ram_readdata;
            ch_ready[gidx] <= 1'b1;
            count          <= count + 8'd1;
            if (count + 8'd1 == ram_burstcnt) begin
              ch_ack[gidx] <= ~ch_ack[gidx];
              state        <= IDLE;
            end
          end
        end
        WR: begin
          if (!ram_waitrequest) begin
            count <= count + 8'd1;
            if (count + 8'd1 == ram_burstcnt) begin
              ram_write    <= 1'b0;
              ch_ack[gidx] <= ~ch_ack[gidx];
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ddr_arb.md
Name: ddr_arb

Overview:
- Round-robin scheduler sharing one 64-bit Avalon-MM DDR port between NCH requesters. Each requester issues a read or a write burst.
- Requesters use a toggle handshake: request pending while ch_req[i] != ch_ack[i].
- Sits between core-side clients (video scanout, CPU cache, DMA) and the HPS DDR bridge.
- Serves one transaction at a time; each channel has at most one transaction outstanding.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- RR_W, 3, width of the grant index register; must satisfy 2**RR_W >= NCH.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ram_waitrequest  in  1  Avalon stall; command outputs hold while high.
- ram_burstcnt  out  8  burst length of the current command.
- ram_addr  out  29  64-bit word address (byte address [31:3]).
- ram_readdata  in  64  read beat data.
- ram_read_ready  in  1  read beat valid.
- ram_read  out  1  read command strobe.
- ram_writedata  out  64  write beat data.
- ram_byteenable  out  8  write byte enables; 8'hFF during reads.
- ram_write  out  1  write command/beat strobe.
- ch_addr  in  NCH x [31:3]  per-channel word address.
- ch_burst  in  NCH x 8  per-channel burst length; 0 is treated as 1.
- ch_we  in  NCH  1 = write transaction, 0 = read transaction.
- ch_req  in  NCH  request toggle.
- ch_ack  out  NCH  completion toggle; equals ch_req when the transaction is complete.
- ch_wdata  in  NCH x 64  current write beat data.
- ch_be  in  NCH x 8  current write beat enables.
- ch_wr_next  out  NCH  write beat accepted; requester presents the next beat from the following cycle.
- ch_rdata  out  64  registered read beat, shared by all channels.
- ch_ready  out  NCH  one-cycle read beat valid, addressed to one channel.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: ram_read=0, ram_write=0, ch_ack=0, ch_ready=0, ch_rdata=0, busy=0, state=IDLE, rr pointer=0, beat count=0. ram_addr and ram_burstcnt reset to 0.
- States: IDLE, RD_CMD, RD_DATA, WR.
- IDLE: the pending set is ch_req ^ ch_ack.
  - Grant goes to the first pending channel at or after rr, searching upward with wrap.
  - On grant: latch address, burst (0 becomes 1) and direction. Next state is RD_CMD or WR.
  - rr becomes grant+1 modulo NCH.
  - No pending channels: remain in IDLE.
- RD_CMD: ram_read=1 with the latched address and burst.
  - Hold while ram_waitrequest=1.
  - On the accepting cycle (read & !waitrequest), go to RD_DATA next cycle with ram_read=0.
- RD_DATA: on each ram_read_ready, ch_rdata<=ram_readdata, ch_ready[g]<=1 for one cycle, beat count++.
  - On the last beat (count+1 == burst), ch_ack[g] toggles in the same edge as ch_ready[g] rises, then go to IDLE.
  - Read beats are accepted regardless of ram_waitrequest.
- WR: ram_write=1; ram_writedata=ch_wdata[g] and ram_byteenable=ch_be[g], both combinational.
  - ram_addr and ram_burstcnt stay constant for the whole burst.
  - ch_wr_next[g] = ram_write & !ram_waitrequest (combinational, one cycle per accepted beat); beat count++ on the same condition.
  - Last accepted beat: ram_write=0 next cycle, ch_ack[g] toggles, go to IDLE.
- Latency:
  - Toggle seen in IDLE at edge n: ram_read/ram_write high from cycle n+1.
  - Read beat on ram_read_ready at edge m: ch_ready high during cycle m+1.
  - One IDLE cycle minimum between transactions.
- A req toggle on a channel whose transaction is in flight stays pending and is served in a later arbitration. The requester must not change ch_addr, ch_burst or ch_we until ack matches req.
- ram_read_ready in IDLE, RD_CMD or WR is ignored (stale beats after reset are discarded).
- Reset mid-transaction: immediate return to IDLE and all reset values apply; an in-flight DDR burst is abandoned. Requesters must reset alongside.
- Burst 255: count is 8-bit; the last-beat compare uses the 8-bit burst with no wrap.

Decomposition:
- Package ddr_arb_pkg: state enum (IDLE, RD_CMD, RD_DATA, WR) and constant BURST_MIN=8'd1.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: pending mask and rr pointer.
  - Outputs: grant index and a valid flag.

Test Plan:
- Single read: ch0 toggles req, addr 0x100, burst 4, waitrequest=0 → ram_read one cycle, ram_addr=0x100>>3, burstcnt=4. Four ch_ready[0] pulses carry the DDR data in order; ch_ack[0] toggles with the 4th pulse.
- Write burst with stall: ch1 write, burst 3, waitrequest high 2 cycles mid-burst → exactly 3 ch_wr_next[1] pulses. ram_writedata sequence equals ch_wdata beats; addr and burstcnt stable; ch_ack[1] toggles after the 3rd beat.
- Fairness: all 4 channels toggle req in the same cycle, rr=0 → service order 0,1,2,3. Re-toggle ch0 during ch1's transaction → order continues 2,3,0.
- Burst 0: read burst 0 → ram_burstcnt=1, one ch_ready pulse, ack toggles.
- Reset in RD_DATA after 2 of 8 beats → next cycle ram_read=0, ch_ack=0, busy=0. Further ram_read_ready beats produce no ch_ready.
- Command stall: waitrequest held 5 cycles during RD_CMD → ram_read stays high with constant addr. Exactly one command is accepted.
